// File: rtl/color_correction_matrix_pkg.sv
// Shared types and constants for the colour correction matrix.
// Coefficients are signed fixed point with FRAC fractional bits.
package isp_ccm_pkg;

    localparam int COEF_W       = 12;
    localparam int FRAC         = 8;
    localparam int CCM_ADDR_MAX = 8;
    localparam int PROD_W       = COEF_W + 9;
    localparam int SUM_W        = PROD_W + 2;
    localparam int RND_W        = SUM_W - FRAC;

    typedef logic signed [COEF_W-1:0] coef_t;
    typedef coef_t [0:2] row_t;
    typedef row_t [0:2] bank_t;

    function automatic bank_t ccm_identity();
        bank_t b;
        b = '0;
        for (int k = 0; k < 3; k++) begin
            b[k][k] = coef_t'(1 << FRAC);
        end
        return b;
    endfunction

    localparam bank_t CCM_IDENTITY = ccm_identity();

endpackage

// File: rtl/color_correction_matrix_if.sv
// Pixel stream and coefficient port bundle for the colour correction matrix.
// CCM_CLIP_COUNT_EN adds the oClipCnt statistics output.
interface color_correction_matrix_if;
    import isp_ccm_pkg::*;

    logic [7:0] iR;
    logic [7:0] iG;
    logic [7:0] iB;
    logic       iValid;
    logic       iDone;
    logic       iCoefWe;
    logic [3:0] iCoefAddr;
    coef_t      iCoefData;
    logic [7:0] oR;
    logic [7:0] oG;
    logic [7:0] oB;
    logic       oValid;
    logic       oDone;
`ifdef CCM_CLIP_COUNT_EN
    logic [15:0] oClipCnt;

    modport master (
        output iR, iG, iB, iValid, iDone, iCoefWe, iCoefAddr, iCoefData,
        input  oR, oG, oB, oValid, oDone, oClipCnt
    );
    modport slave (
        input  iR, iG, iB, iValid, iDone, iCoefWe, iCoefAddr, iCoefData,
        output oR, oG, oB, oValid, oDone, oClipCnt
    );
`else
    modport master (
        output iR, iG, iB, iValid, iDone, iCoefWe, iCoefAddr, iCoefData,
        input  oR, oG, oB, oValid, oDone
    );
    modport slave (
        input  iR, iG, iB, iValid, iDone, iCoefWe, iCoefAddr, iCoefData,
        output oR, oG, oB, oValid, oDone
    );
`endif

endinterface

// File: rtl/color_correction_matrix_channel.sv
// One matrix row: three products, rounded sum, clamp to 8 bits.
// Three register stages; clip flags the value entering the last stage.
module ccm_channel
    import isp_ccm_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] r,
    input  logic [7:0] g,
    input  logic [7:0] b,
    input  row_t       coef,
    output logic [7:0] pix,
    output logic       clip
);

    localparam logic signed [SUM_W-1:0] HALF = SUM_W'(1 << (FRAC - 1));

    logic signed [8:0]        px   [3];
    logic signed [PROD_W-1:0] prod [3];
    logic signed [SUM_W-1:0]  sum;
    logic signed [RND_W-1:0]  rnd;
    logic                     low;
    logic                     high;

    assign px[0] = $signed({1'b0, r});
    assign px[1] = $signed({1'b0, g});
    assign px[2] = $signed({1'b0, b});

    assign sum  = prod[0] + prod[1] + prod[2] + HALF;
    assign low  = rnd < 0;
    assign high = rnd > 255;
    assign clip = low | high;

    // S1: register the three signed products against the active row
    always_ff @(posedge clk) begin
        for (int j = 0; j < 3; j++) begin
            if (reset) prod[j] <= '0;
            else       prod[j] <= px[j] * $signed(coef[j]);
        end
    end

    // S2: register the rounded, rescaled row sum
    always_ff @(posedge clk) begin
        if (reset) rnd <= '0;
        else       rnd <= RND_W'(sum >>> FRAC);
    end

    // S3: register the clamped 8-bit result
    always_ff @(posedge clk) begin
        if (reset)     pix <= '0;
        else if (low)  pix <= 8'd0;
        else if (high) pix <= 8'd255;
        else           pix <= rnd[7:0];
    end

endmodule

// File: rtl/color_correction_matrix.sv
// Streaming 3x3 colour correction with shadow/active coefficient banks.
// Optional CCM_CLIP_COUNT_EN adds a per-frame clipped-pixel counter.
module color_correction_matrix
    import isp_ccm_pkg::*;
#(
    parameter int width  = 320,
    parameter int height = 240
) (
    input logic                     clk,
    input logic                     reset,
    color_correction_matrix_if.slave bus
);

    localparam int PIX_N = width * height;
    localparam int CNT_W = $clog2(PIX_N);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PIX_N - 1);

    bank_t            shadow;
    bank_t            active;
    logic             pending;
    logic             commit;
    logic             idle;
    logic             wr_ok;
    logic [1:0]       wrow;
    logic [1:0]       wcol;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       vld;
    logic [2:0]       dn;
    logic [7:0]       pix [3];
    logic [2:0]       clip;

    assign wr_ok  = bus.iCoefWe && (bus.iCoefAddr <= 4'(CCM_ADDR_MAX));
    assign idle   = (cnt == '0) && (vld == 3'b000);
    assign commit = pending && (bus.iDone || idle);

    // Split the row-major coefficient address into row and column
    always_comb begin
        wrow = 2'(bus.iCoefAddr / 4'd3);
        wcol = 2'(bus.iCoefAddr % 4'd3);
    end

    // Shadow writes; copy to active only at a frame boundary or when idle
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow  <= CCM_IDENTITY;
            active  <= CCM_IDENTITY;
            pending <= 1'b0;
        end else begin
            if (commit) active <= shadow;
            if (wr_ok) begin
                shadow[wrow][wcol] <= bus.iCoefData;
                pending            <= 1'b1;
            end else if (commit) begin
                pending <= 1'b0;
            end
        end
    end

    // Pixel position within the frame; end-of-frame pulse restarts it
    always_ff @(posedge clk) begin
        if (reset || bus.iDone) cnt <= '0;
        else if (bus.iValid)    cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
    end

    // Valid and done ride alongside the three datapath stages
    always_ff @(posedge clk) begin
        if (reset) begin
            vld <= '0;
            dn  <= '0;
        end else begin
            vld <= {vld[1:0], bus.iValid};
            dn  <= {dn[1:0], bus.iDone};
        end
    end

    for (genvar k = 0; k < 3; k++) begin : g_ch
        ccm_channel u_ch (
            .clk   (clk),
            .reset (reset),
            .r     (bus.iR),
            .g     (bus.iG),
            .b     (bus.iB),
            .coef  (active[k]),
            .pix   (pix[k]),
            .clip  (clip[k])
        );
    end

    assign bus.oR     = pix[0];
    assign bus.oG     = pix[1];
    assign bus.oB     = pix[2];
    assign bus.oValid = vld[2];
    assign bus.oDone  = dn[2];

`ifdef CCM_CLIP_COUNT_EN
    logic [2:0]  first;
    logic [15:0] clip_cnt;

    // Mark the first pixel of each frame as it travels down the pipe
    always_ff @(posedge clk) begin
        if (reset) first <= '0;
        else       first <= {first[1:0], bus.iValid && (cnt == '0)};
    end

    // Count clipped pixels at S3; restart on a new frame, saturate at max
    always_ff @(posedge clk) begin
        if (reset) begin
            clip_cnt <= '0;
        end else if (vld[1]) begin
            if (first[1])
                clip_cnt <= {15'd0, |clip};
            else if (|clip && clip_cnt != 16'hFFFF)
                clip_cnt <= clip_cnt + 16'd1;
        end
    end

    assign bus.oClipCnt = clip_cnt;
`else
    logic unused_clip;
    assign unused_clip = ^clip;
`endif

endmodule

// File: tb/tb_color_correction_matrix.sv
// Directed bench for color_correction_matrix with an output scoreboard.
// Define CCM_CLIP_COUNT_EN to also check oClipCnt.
module tb_color_correction_matrix;
    import isp_ccm_pkg::*;

    typedef struct {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        int         cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    bit   mon_en = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   act [9];
    int   shd [9];
    exp_t sb [$];
    int   dq [$];

    color_correction_matrix_if bus ();

    color_correction_matrix dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic logic [7:0] model(input int k, input int r,
                                         input int g, input int b);
        int s;
        s = act[3*k] * r + act[3*k+1] * g + act[3*k+2] * b + 128;
        s = s >>> 8;
        if (s < 0) return 8'd0;
        if (s > 255) return 8'd255;
        return s[7:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input int r, input int g, input int b,
                         input bit d, input bit we, input int a,
                         input int data);
        exp_t e;
        @(posedge clk);
        #1;
        bus.iValid    = v;
        bus.iR        = 8'(r);
        bus.iG        = 8'(g);
        bus.iB        = 8'(b);
        bus.iDone     = d;
        bus.iCoefWe   = we;
        bus.iCoefAddr = 4'(a);
        bus.iCoefData = coef_t'(data);
        if (v) begin
            e.r   = model(0, r, g, b);
            e.g   = model(1, r, g, b);
            e.b   = model(2, r, g, b);
            e.cyc = cyc + 3;
            sb.push_back(e);
        end
        if (d) dq.push_back(cyc + 3);
        if (we && a <= 8) shd[a] = data;
    endtask

    task automatic pix(input int r, input int g, input int b);
        drive(1'b1, r, g, b, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic wr(input int a, input int data);
        drive(1'b0, 0, 0, 0, 1'b0, 1'b1, a, data);
    endtask

    task automatic done_pulse();
        drive(1'b0, 0, 0, 0, 1'b1, 1'b0, 0, 0);
        idle(3);
    endtask

    task automatic commit_idle();
        idle(1);
        act = shd;
    endtask

    task automatic set_identity();
        for (int i = 0; i < 9; i++) begin
            act[i] = (i % 4 == 0) ? 256 : 0;
            shd[i] = act[i];
        end
    endtask

    // Scoreboard monitor: compare every output cycle against expectations
    always @(negedge clk) begin
        exp_t e;
        logic exp_done;
        if (mon_en) begin
            exp_done = (dq.size() != 0) && (dq[0] == cyc);
            if (exp_done) void'(dq.pop_front());
            checks++;
            assert (bus.oDone === exp_done) else begin
                failures++;
                $error("FAIL oDone observed=%b expected=%b cyc=%0d",
                       bus.oDone, exp_done, cyc);
            end
            if (bus.oValid === 1'b1) begin
                checks++;
                assert (sb.size() != 0) else begin
                    failures++;
                    $error("FAIL unexpected_valid observed=1 expected=0 cyc=%0d",
                           cyc);
                end
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    checks++;
                    assert ({bus.oR, bus.oG, bus.oB} === {e.r, e.g, e.b}) else begin
                        failures++;
                        $error("FAIL pixel observed=%0d,%0d,%0d expected=%0d,%0d,%0d cyc=%0d",
                               bus.oR, bus.oG, bus.oB, e.r, e.g, e.b, cyc);
                    end
                    checks++;
                    assert (cyc === e.cyc) else begin
                        failures++;
                        $error("FAIL latency observed_cyc=%0d expected_cyc=%0d",
                               cyc, e.cyc);
                    end
                end
            end else if (sb.size() != 0) begin
                checks++;
                assert (sb[0].cyc > cyc) else begin
                    failures++;
                    $error("FAIL missing_valid observed=%b expected=1 cyc=%0d",
                           bus.oValid, cyc);
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        bus.iValid    = 1'b0;
        bus.iR        = '0;
        bus.iG        = '0;
        bus.iB        = '0;
        bus.iDone     = 1'b0;
        bus.iCoefWe   = 1'b0;
        bus.iCoefAddr = '0;
        bus.iCoefData = '0;
        set_identity();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_oValid", 32'(bus.oValid), 32'd0);
        chk("rst_oDone", 32'(bus.oDone), 32'd0);
        chk("rst_pixel", {8'd0, bus.oR, bus.oG, bus.oB}, 32'd0);
`ifdef CCM_CLIP_COUNT_EN
        chk("rst_clip", 32'(bus.oClipCnt), 32'd0);
`endif
        reset  = 1'b0;
        mon_en = 1'b1;

        // identity after reset
        pix(10, 200, 255);
        pix(0, 128, 1);
        idle(4);
        done_pulse();

        // channel swap, plus an ignored out-of-range address
        wr(0, 0);   wr(1, 256); wr(2, 0);
        wr(3, 0);   wr(4, 0);   wr(5, 256);
        wr(6, 256); wr(7, 0);   wr(8, 0);
        wr(12, 100);
        commit_idle();
        pix(1, 2, 3);
        pix(255, 0, 77);
        idle(4);
        done_pulse();

        // clamp low then high on the red row
        wr(0, -512); wr(1, 0); wr(2, 0);
        commit_idle();
        pix(100, 0, 0);
        idle(4);
        done_pulse();
        wr(0, 512);
        commit_idle();
        pix(200, 0, 0);
        idle(4);
        done_pulse();

`ifdef CCM_CLIP_COUNT_EN
        wr(0, -512); wr(1, 512);
        commit_idle();
        pix(100, 0, 0);
        pix(0, 200, 0);
        idle(3);
        chk("clip_cnt_two", 32'(bus.oClipCnt), 32'd2);
        done_pulse();
        chk("clip_cnt_hold", 32'(bus.oClipCnt), 32'd2);
`endif

        // rounding half up, and negative result clamps to zero
        wr(0, 128); wr(1, 0); wr(2, 0);
        commit_idle();
        pix(3, 0, 0);
        idle(3);
`ifdef CCM_CLIP_COUNT_EN
        chk("clip_cnt_new_frame", 32'(bus.oClipCnt), 32'd0);
`endif
        idle(1);
        done_pulse();
        wr(0, -128);
        commit_idle();
        pix(3, 0, 0);
        idle(4);

        // reset mid-frame with a pending write
        pix(40, 50, 60);
        pix(41, 51, 61);
        wr(0, 77);
        pix(42, 52, 62);
        pix(43, 53, 63);
        @(posedge clk);
        #1;
        reset         = 1'b1;
        bus.iValid    = 1'b0;
        bus.iCoefWe   = 1'b0;
        bus.iDone     = 1'b0;
        @(posedge clk);
        #1;
        sb.delete();
        dq.delete();
        chk("midrst_oValid", 32'(bus.oValid), 32'd0);
        chk("midrst_oR", 32'(bus.oR), 32'd0);
        reset = 1'b0;
        set_identity();
        idle(2);
        pix(50, 60, 70);
        pix(250, 5, 128);
        idle(4);
        done_pulse();

        // full frame with a mid-frame write; takes effect after iDone
        for (int i = 0; i < 76800; i++) begin
            drive(1'b1, i % 256, (i * 7) % 256, 255 - (i % 256),
                  i == 76799, i == 100, 0, 0);
        end
        act = shd;
        pix(123, 45, 67);
        idle(5);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        chk("done_drained", 32'(dq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
